// File: rtl/sdram_req_arb.sv
`default_nettype none
// ============================================================================
// Module      : sdram_req_arb
// Description : Fair write/read burst request arbiter with region addressing.
// Revision    : 1.0
// ============================================================================
module sdram_req_arb #(
    parameter int AW = 24,
    parameter int FW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sdram_init_done,
    input  logic          sdram_wr_ack,
    input  logic          sdram_rd_ack,
    input  logic [FW-1:0] wrf_use,
    input  logic [FW-1:0] rdf_use,
    input  logic          rd_valid,
    input  logic [8:0]    wr_len,
    input  logic [8:0]    rd_len,
    input  logic [AW-1:0] wr_min_addr,
    input  logic [AW-1:0] wr_max_addr,
    input  logic [AW-1:0] rd_min_addr,
    input  logic [AW-1:0] rd_max_addr,
    input  logic          wr_load,
    input  logic          rd_load,
    output logic          sdram_wr_req,
    output logic          sdram_rd_req,
    output logic [8:0]    sdram_wr_burst,
    output logic [8:0]    sdram_rd_burst,
    output logic [AW-1:0] sdram_wr_addr,
    output logic [AW-1:0] sdram_rd_addr
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_BUSY = 3'd2,
        RD_REQ  = 3'd3,
        RD_BUSY = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic r_wr_ack_d, r_rd_ack_d;
    logic r_last_wr;
    logic r_wr_load_pend, r_rd_load_pend;

    logic w_wr_pend, w_rd_pend;
    logic w_wr_start, w_rd_start;
    logic w_wr_got_ack, w_rd_got_ack;
    logic w_wr_done, w_rd_done;
    logic w_wr_active, w_rd_active;
    logic [AW-1:0] w_wr_sum, w_rd_sum, w_wr_adv, w_rd_adv;

    assign w_wr_pend   = 32'(wrf_use) >= 32'(wr_len);
    assign w_rd_pend   = rd_valid && (32'(rdf_use) < 32'(rd_len));
    assign w_wr_active = (r_state == WR_REQ) || (r_state == WR_BUSY);
    assign w_rd_active = (r_state == RD_REQ) || (r_state == RD_BUSY);

    // Next burst start wraps back to the region base once it reaches the top.
    assign w_wr_sum = sdram_wr_addr + AW'(sdram_wr_burst);
    assign w_rd_sum = sdram_rd_addr + AW'(sdram_rd_burst);
    assign w_wr_adv = (w_wr_sum >= wr_max_addr) ? wr_min_addr : w_wr_sum;
    assign w_rd_adv = (w_rd_sum >= rd_max_addr) ? rd_min_addr : w_rd_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_wr_start   = 1'b0;
        w_rd_start   = 1'b0;
        w_wr_got_ack = 1'b0;
        w_rd_got_ack = 1'b0;
        w_wr_done    = 1'b0;
        w_rd_done    = 1'b0;
        if (!sdram_init_done) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    // With both pending, serve whichever source did not go last.
                    if (w_wr_pend && (!w_rd_pend || !r_last_wr)) begin
                        w_state_next = WR_REQ;
                        w_wr_start   = 1'b1;
                    end else if (w_rd_pend) begin
                        w_state_next = RD_REQ;
                        w_rd_start   = 1'b1;
                    end
                end
                WR_REQ: begin
                    if (sdram_wr_ack) begin
                        w_state_next = WR_BUSY;
                        w_wr_got_ack = 1'b1;
                    end
                end
                WR_BUSY: begin
                    if (r_wr_ack_d && !sdram_wr_ack) begin
                        w_state_next = IDLE;
                        w_wr_done    = 1'b1;
                    end
                end
                RD_REQ: begin
                    if (sdram_rd_ack) begin
                        w_state_next = RD_BUSY;
                        w_rd_got_ack = 1'b1;
                    end
                end
                RD_BUSY: begin
                    if (r_rd_ack_d && !sdram_rd_ack) begin
                        w_state_next = IDLE;
                        w_rd_done    = 1'b1;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ack_d     <= 1'b0;
            r_rd_ack_d     <= 1'b0;
            r_last_wr      <= 1'b0;
            r_wr_load_pend <= 1'b0;
            r_rd_load_pend <= 1'b0;
            sdram_wr_req   <= 1'b0;
            sdram_rd_req   <= 1'b0;
            sdram_wr_burst <= 9'd0;
            sdram_rd_burst <= 9'd0;
            sdram_wr_addr  <= '0;
            sdram_rd_addr  <= '0;
        end else begin
            r_wr_ack_d <= sdram_wr_ack;
            r_rd_ack_d <= sdram_rd_ack;
            if (!sdram_init_done) begin
                sdram_wr_req   <= 1'b0;
                sdram_rd_req   <= 1'b0;
                sdram_wr_addr  <= wr_min_addr;
                sdram_rd_addr  <= rd_min_addr;
                r_wr_load_pend <= 1'b0;
                r_rd_load_pend <= 1'b0;
            end else begin
                if (w_wr_start) begin
                    sdram_wr_req   <= 1'b1;
                    sdram_wr_burst <= wr_len;
                    r_last_wr      <= 1'b1;
                end else if (w_wr_got_ack) begin
                    sdram_wr_req <= 1'b0;
                end
                if (w_rd_start) begin
                    sdram_rd_req   <= 1'b1;
                    sdram_rd_burst <= rd_len;
                    r_last_wr      <= 1'b0;
                end else if (w_rd_got_ack) begin
                    sdram_rd_req <= 1'b0;
                end

                // A load seen mid-burst is deferred so the address stays stable.
                if (w_wr_done) begin
                    sdram_wr_addr  <= (r_wr_load_pend || wr_load) ? wr_min_addr : w_wr_adv;
                    r_wr_load_pend <= 1'b0;
                end else if (wr_load && !w_wr_active) begin
                    sdram_wr_addr <= wr_min_addr;
                end else if (wr_load) begin
                    r_wr_load_pend <= 1'b1;
                end

                if (w_rd_done) begin
                    sdram_rd_addr  <= (r_rd_load_pend || rd_load) ? rd_min_addr : w_rd_adv;
                    r_rd_load_pend <= 1'b0;
                end else if (rd_load && !w_rd_active) begin
                    sdram_rd_addr <= rd_min_addr;
                end else if (rd_load) begin
                    r_rd_load_pend <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_req_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_req_arb
// Description : Directed self-checking bench for sdram_req_arb.
// Revision    : 1.0
// ============================================================================
module tb_sdram_req_arb;

    localparam int AW = 24;
    localparam int FW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sdram_init_done;
    logic          sdram_wr_ack, sdram_rd_ack;
    logic [FW-1:0] wrf_use, rdf_use;
    logic          rd_valid;
    logic [8:0]    wr_len, rd_len;
    logic [AW-1:0] wr_min_addr, wr_max_addr, rd_min_addr, rd_max_addr;
    logic          wr_load, rd_load;
    logic          sdram_wr_req, sdram_rd_req;
    logic [8:0]    sdram_wr_burst, sdram_rd_burst;
    logic [AW-1:0] sdram_wr_addr, sdram_rd_addr;

    int errors  = 0;
    int checks  = 0;
    int overlap = 0;

    sdram_req_arb #(.AW(AW), .FW(FW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sdram_init_done (sdram_init_done),
        .sdram_wr_ack    (sdram_wr_ack),
        .sdram_rd_ack    (sdram_rd_ack),
        .wrf_use         (wrf_use),
        .rdf_use         (rdf_use),
        .rd_valid        (rd_valid),
        .wr_len          (wr_len),
        .rd_len          (rd_len),
        .wr_min_addr     (wr_min_addr),
        .wr_max_addr     (wr_max_addr),
        .rd_min_addr     (rd_min_addr),
        .rd_max_addr     (rd_max_addr),
        .wr_load         (wr_load),
        .rd_load         (rd_load),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_rd_req    (sdram_rd_req),
        .sdram_wr_burst  (sdram_wr_burst),
        .sdram_rd_burst  (sdram_rd_burst),
        .sdram_wr_addr   (sdram_wr_addr),
        .sdram_rd_addr   (sdram_rd_addr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sdram_wr_req && sdram_rd_req) overlap++;
    end

    // Stimulus helpers: bounded wait for a request, and an ack pulse of n cycles.
    task automatic wait_req(input bit is_wr, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ((is_wr ? sdram_wr_req : sdram_rd_req) === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_any(output int kind);
        kind = 0;
        for (int i = 0; i < 20; i++) begin
            if (sdram_wr_req === 1'b1) begin kind = 1; break; end
            if (sdram_rd_req === 1'b1) begin kind = 2; break; end
            @(negedge clk);
        end
    endtask

    task automatic handshake(input bit is_wr, input int n);
        if (is_wr) sdram_wr_ack = 1'b1; else sdram_rd_ack = 1'b1;
        repeat (n) @(negedge clk);
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if (sdram_wr_req !== 1'b0 || sdram_rd_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_req: wr=%b rd=%b expected 0 0", sdram_wr_req, sdram_rd_req);
        end
        checks++;
        if (sdram_wr_burst !== 9'd0 || sdram_rd_burst !== 9'd0) begin
            errors++;
            $display("FAIL reset_burst: wr=%0d rd=%0d expected 0 0", sdram_wr_burst, sdram_rd_burst);
        end
        checks++;
        if (sdram_wr_addr !== 24'd0 || sdram_rd_addr !== 24'd0) begin
            errors++;
            $display("FAIL reset_addr: wr=%h rd=%h expected 0 0", sdram_wr_addr, sdram_rd_addr);
        end
    endtask

    task automatic test_init_hold;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (sdram_wr_req !== 1'b0) begin
            errors++;
            $display("FAIL init_hold_req: wr_req=%b expected 0", sdram_wr_req);
        end
        checks++;
        if (sdram_wr_addr !== 24'd0 || sdram_rd_addr !== 24'h001000) begin
            errors++;
            $display("FAIL init_hold_addr: wr=%h rd=%h expected 000000 001000", sdram_wr_addr, sdram_rd_addr);
        end
        sdram_init_done = 1'b1;
        @(negedge clk);
        checks++;
        if (sdram_wr_req !== 1'b1 || sdram_rd_req !== 1'b0 || sdram_wr_burst !== 9'd256) begin
            errors++;
            $display("FAIL init_first_req: wr_req=%b rd_req=%b burst=%0d expected 1 0 256",
                     sdram_wr_req, sdram_rd_req, sdram_wr_burst);
        end
    endtask

    task automatic test_write_burst;
        sdram_wr_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (sdram_wr_req !== 1'b0) begin
            errors++;
            $display("FAIL wr_req_drop: wr_req=%b expected 0", sdram_wr_req);
        end
        repeat (254) @(negedge clk);
        checks++;
        if (sdram_wr_addr !== 24'd0 || sdram_wr_burst !== 9'd256) begin
            errors++;
            $display("FAIL wr_stable: addr=%h burst=%0d expected 000000 256", sdram_wr_addr, sdram_wr_burst);
        end
        sdram_wr_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (sdram_wr_addr !== 24'd256 || sdram_wr_req !== 1'b0) begin
            errors++;
            $display("FAIL wr_advance: addr=%h req=%b expected 000100 0", sdram_wr_addr, sdram_wr_req);
        end
    endtask

    task automatic test_wrap;
        logic [AW-1:0] exp_addr [4];
        bit seen;
        exp_addr[0] = 24'd256;
        exp_addr[1] = 24'd512;
        exp_addr[2] = 24'd768;
        exp_addr[3] = 24'd0;
        for (int i = 0; i < 4; i++) begin
            wait_req(1'b1, seen);
            checks++;
            if (!seen || sdram_wr_addr !== exp_addr[i]) begin
                errors++;
                $display("FAIL wrap_addr[%0d]: seen=%b addr=%h expected %h", i, seen, sdram_wr_addr, exp_addr[i]);
            end
            handshake(1'b1, 4);
        end
        wrf_use = '0;
    endtask

    task automatic test_alternate;
        int kind;
        int exp_kind [4];
        logic [AW-1:0] exp_addr [4];
        logic [AW-1:0] got_addr;
        exp_kind[0] = 1; exp_addr[0] = 24'h000000;
        exp_kind[1] = 2; exp_addr[1] = 24'h001000;
        exp_kind[2] = 1; exp_addr[2] = 24'h000100;
        exp_kind[3] = 2; exp_addr[3] = 24'h001080;
        rst_n = 1'b0;
        sdram_init_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        wrf_use = 10'd300;
        rd_valid = 1'b1;
        rdf_use = 10'd0;
        sdram_init_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_any(kind);
            got_addr = (kind == 2) ? sdram_rd_addr : sdram_wr_addr;
            checks++;
            if (kind != exp_kind[i] || got_addr !== exp_addr[i]) begin
                errors++;
                $display("FAIL alt_grant[%0d]: kind=%0d addr=%h expected kind=%0d addr=%h",
                         i, kind, got_addr, exp_kind[i], exp_addr[i]);
            end
            handshake(kind == 1, 3);
        end
        wrf_use = '0;
        rd_valid = 1'b0;
        checks++;
        if (sdram_rd_burst !== 9'd128) begin
            errors++;
            $display("FAIL alt_rd_burst: burst=%0d expected 128", sdram_rd_burst);
        end
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL both_req_high: cycles=%0d expected 0", overlap);
        end
    endtask

    task automatic test_load_busy;
        bit seen;
        wrf_use = 10'd300;
        wait_req(1'b1, seen);
        checks++;
        if (!seen || sdram_wr_addr !== 24'd512) begin
            errors++;
            $display("FAIL load_pre_addr: seen=%b addr=%h expected 000200", seen, sdram_wr_addr);
        end
        sdram_wr_ack = 1'b1;
        repeat (2) @(negedge clk);
        wr_load = 1'b1;
        @(negedge clk);
        wr_load = 1'b0;
        wrf_use = '0;
        checks++;
        if (sdram_wr_addr !== 24'd512 || sdram_wr_burst !== 9'd256) begin
            errors++;
            $display("FAIL load_busy_stable: addr=%h burst=%0d expected 000200 256", sdram_wr_addr, sdram_wr_burst);
        end
        repeat (2) @(negedge clk);
        sdram_wr_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (sdram_wr_addr !== 24'd0) begin
            errors++;
            $display("FAIL load_busy_end: addr=%h expected 000000", sdram_wr_addr);
        end
        rd_load = 1'b1;
        @(negedge clk);
        rd_load = 1'b0;
        checks++;
        if (sdram_rd_addr !== 24'h001000) begin
            errors++;
            $display("FAIL load_idle_rd: addr=%h expected 001000", sdram_rd_addr);
        end
    endtask

    task automatic test_reset_midburst;
        bit seen;
        rd_valid = 1'b1;
        rdf_use = 10'd0;
        wait_req(1'b0, seen);
        handshake(1'b0, 3);
        wait_req(1'b0, seen);
        checks++;
        if (!seen || sdram_rd_addr !== 24'h001080) begin
            errors++;
            $display("FAIL rd_second_addr: seen=%b addr=%h expected 001080", seen, sdram_rd_addr);
        end
        sdram_rd_ack = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (sdram_rd_req !== 1'b0 || sdram_rd_addr !== 24'd0 || sdram_rd_burst !== 9'd0 ||
            sdram_wr_addr !== 24'd0 || sdram_wr_burst !== 9'd0 || sdram_wr_req !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: rd_req=%b rd_addr=%h rd_burst=%0d wr_req=%b wr_addr=%h wr_burst=%0d expected all 0",
                     sdram_rd_req, sdram_rd_addr, sdram_rd_burst, sdram_wr_req, sdram_wr_addr, sdram_wr_burst);
        end
        sdram_rd_ack = 1'b0;
        sdram_init_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (sdram_rd_req !== 1'b0 || sdram_rd_addr !== 24'h001000) begin
            errors++;
            $display("FAIL recover_hold: rd_req=%b addr=%h expected 0 001000", sdram_rd_req, sdram_rd_addr);
        end
        sdram_init_done = 1'b1;
        wait_req(1'b0, seen);
        checks++;
        if (!seen || sdram_rd_addr !== 24'h001000 || sdram_rd_burst !== 9'd128) begin
            errors++;
            $display("FAIL recover_req: seen=%b addr=%h burst=%0d expected 1 001000 128",
                     seen, sdram_rd_addr, sdram_rd_burst);
        end
        handshake(1'b0, 2);
        rd_valid = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        sdram_init_done = 1'b0;
        sdram_wr_ack    = 1'b0;
        sdram_rd_ack    = 1'b0;
        wrf_use         = 10'd300;
        rdf_use         = 10'd0;
        rd_valid        = 1'b0;
        wr_len          = 9'd256;
        rd_len          = 9'd128;
        wr_min_addr     = 24'h000000;
        wr_max_addr     = 24'h000400;
        rd_min_addr     = 24'h001000;
        rd_max_addr     = 24'h001400;
        wr_load         = 1'b0;
        rd_load         = 1'b0;

        test_reset();
        test_init_hold();
        test_write_burst();
        test_wrap();
        test_alternate();
        test_load_busy();
        test_reset_midburst();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
